// File: rtl/load_store_unit.sv
// RV32I load/store unit: classifies an access, runs one word-wide memory
// transaction with lane steering and a bounded ack wait, returns a one-cycle response.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;
  typedef enum logic [1:0] {
    RC_OK       = 2'b00,
    RC_MISALIGN = 2'b01,
    RC_ILLEGAL  = 2'b10,
    RC_TIMEOUT  = 2'b11
  } rsp_code_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  rsp_code_t   r_code, w_code;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [7:0]  r_cnt;

  logic        w_accept, w_illegal, w_misaligned, w_cnt_last, w_bus;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_bus    = (r_state == S_BUS);
  assign w_cnt_last = (r_cnt == LP_CNT_LAST);

  assign w_illegal = req_store ? !(req_funct3 inside {3'b000, 3'b001, 3'b010})
                               :  (req_funct3 inside {3'b011, 3'b110, 3'b111});
  // Bits [1:0] of funct3 encode the width for both loads and stores.
  assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_code = w_illegal    ? RC_ILLEGAL  :
                  w_misaligned ? RC_MISALIGN : RC_OK;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (w_code == RC_OK) ? S_BUS : S_RESP;
      S_BUS:   if (mem_ack || w_cnt_last) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset as well, because the memory and
  // response ports are required to read as zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_store  <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_code   <= RC_OK;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_store  <= req_store;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_rdata  <= '0;
      r_code   <= w_code;
      r_cnt    <= '0;
    end else if (w_bus) begin
      if (mem_ack)         r_rdata <= mem_rdata;
      else if (w_cnt_last) r_code  <= RC_TIMEOUT;
      else                 r_cnt   <= r_cnt + 8'd1;
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_code  = rsp_valid ? r_code : RC_OK;
  assign mem_req   = w_bus;
  assign mem_we    = w_bus && r_store;
  assign mem_addr  = w_bus ? {r_addr[31:2], 2'b00} : 32'd0;

  // Lane steering; only legal widths can reach BUS.
  always_comb begin
    mem_wstrb = 4'b0000;
    mem_wdata = 32'd0;
    if (w_bus && r_store) begin
      unique case (r_funct3[1:0])
        2'b00: begin
          mem_wstrb = 4'b0001 << r_addr[1:0];
          mem_wdata = {4{r_wdata[7:0]}};
        end
        2'b01: begin
          mem_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{r_wdata[15:0]}};
        end
        default: begin
          mem_wstrb = 4'b1111;
          mem_wdata = r_wdata;
        end
      endcase
    end
  end

  assign w_byte = r_rdata[8*r_addr[1:0] +: 8];
  assign w_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];

  always_comb begin
    rsp_rdata = 32'd0;
    if (rsp_valid && (r_code == RC_OK) && !r_store) begin
      case (r_funct3)
        3'b000:  rsp_rdata = {{24{w_byte[7]}}, w_byte};
        3'b001:  rsp_rdata = {{16{w_half[15]}}, w_half};
        3'b010:  rsp_rdata = r_rdata;
        3'b100:  rsp_rdata = {24'd0, w_byte};
        3'b101:  rsp_rdata = {16'd0, w_half};
        default: rsp_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: lane steering, load
// extension, error codes, ack timeout, mid-access reset and issue spacing.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_code;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_code(rsp_code),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Outputs are sampled and inputs changed 1 ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns in the cycle after accept.
  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    check("ready_before_issue", 32'(req_ready), 32'd1);
    tick;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] exp_maddr, input logic [31:0] rd,
                         input logic [31:0] exp_data);
    issue(1'b0, f3, addr, 32'd0);
    check({tag, "_mem_req"},  32'(mem_req),   32'd1);
    check({tag, "_mem_addr"}, mem_addr,       exp_maddr);
    check({tag, "_wstrb"},    32'(mem_wstrb), 32'd0);
    check({tag, "_we"},       32'(mem_we),    32'd0);
    mem_ack = 1'b1; mem_rdata = rd;
    tick;
    mem_ack = 1'b0; mem_rdata = '0;
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rsp_code"},  32'(rsp_code),  32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata,      exp_data);
    check({tag, "_req_drop"},  32'(mem_req),   32'd0);
    tick;
    check({tag, "_rsp_end"},   32'(rsp_valid), 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_maddr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                          input int wait_cycles);
    issue(1'b1, f3, addr, wd);
    for (int i = 0; i <= wait_cycles; i++) begin
      check({tag, "_mem_req"},  32'(mem_req),   32'd1);
      check({tag, "_we"},       32'(mem_we),    32'd1);
      check({tag, "_mem_addr"}, mem_addr,       exp_maddr);
      check({tag, "_wstrb"},    32'(mem_wstrb), 32'(exp_strb));
      check({tag, "_wdata"},    mem_wdata,      exp_wdata);
      check({tag, "_busy"},     32'(req_ready), 32'd0);
      if (i == wait_cycles) begin mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      tick;
    end
    mem_ack = 1'b0; mem_rdata = '0;
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rsp_code"},  32'(rsp_code),  32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata,      32'd0);
    tick;
  endtask

  task automatic do_err(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [1:0] exp_code);
    issue(st, f3, addr, 32'hFFFF_FFFF);
    check({tag, "_no_mem_req"}, 32'(mem_req),   32'd0);
    check({tag, "_rsp_valid"},  32'(rsp_valid), 32'd1);
    check({tag, "_rsp_code"},   32'(rsp_code),  32'(exp_code));
    check({tag, "_rsp_rdata"},  rsp_rdata,      32'd0);
    tick;
    check({tag, "_rsp_end"},    32'(rsp_valid), 32'd0);
  endtask

  // Counts mem_req cycles until rsp_valid; acks in the ack_at-th BUS cycle (0 = never).
  task automatic do_wait(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input int ack_at, input logic [31:0] rd, input int exp_n,
                         input logic [1:0] exp_code, input logic [31:0] exp_data);
    int n = 0;
    logic seen = 1'b0;
    logic [1:0]  got_code = '0;
    logic [31:0] got_data = '0;
    issue(1'b0, f3, addr, 32'd0);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (rsp_valid) begin
        seen = 1'b1; got_code = rsp_code; got_data = rsp_rdata;
      end else begin
        if (mem_req) n++;
        mem_ack   = (ack_at != 0) && (n == ack_at);
        mem_rdata = mem_ack ? rd : 32'd0;
        tick;
      end
    end
    mem_ack = 1'b0; mem_rdata = '0;
    check({tag, "_rsp_seen"}, 32'(seen),     32'd1);
    check({tag, "_req_cyc"},  32'(n),        32'(exp_n));
    check({tag, "_rsp_code"}, 32'(got_code), 32'(exp_code));
    check({tag, "_rsp_data"}, got_data,      exp_data);
    tick;
  endtask

  initial begin
    int acc_n, rsp_n, last_acc, min_gap, bad_addr, bad_ready, bad_data;

    rst = 1'b0;
    tick; tick;
    check("rst_ready",     32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_code",  32'(rsp_code),  32'd0);
    check("rst_rsp_rdata", rsp_rdata,      32'd0);
    check("rst_mem_req",   32'(mem_req),   32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_wstrb",     32'(mem_wstrb), 32'd0);
    check("rst_mem_addr",  mem_addr,       32'd0);
    check("rst_mem_wdata", mem_wdata,      32'd0);
    rst = 1'b1;
    tick;

    do_load("lb",  3'b000, 32'h0000_0103, 32'h0000_0100, 32'h80FF_1234, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_0101, 32'h0000_0100, 32'h80FF_1234, 32'h0000_0012);
    do_load("lh",  3'b001, 32'h0000_0012, 32'h0000_0010, 32'h89AB_CDEF, 32'hFFFF_89AB);
    do_load("lhu", 3'b101, 32'h0000_0012, 32'h0000_0010, 32'h89AB_CDEF, 32'h0000_89AB);
    do_load("lh0", 3'b001, 32'h0000_0010, 32'h0000_0010, 32'h89AB_7DEF, 32'h0000_7DEF);
    do_load("lw",  3'b010, 32'h0000_0F04, 32'h0000_0F04, 32'h1357_9BDF, 32'h1357_9BDF);

    do_store("sh", 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 1);
    do_store("sh0", 3'b001, 32'h0000_0300, 32'h1234_5678, 32'h0000_0300, 4'b0011, 32'h5678_5678, 0);
    do_store("sb", 3'b000, 32'h0000_0001, 32'h1234_5677, 32'h0000_0000, 4'b0010, 32'h7777_7777, 0);
    do_store("sw", 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 32'h0000_0040, 4'b1111, 32'hCAFE_F00D, 0);

    do_err("lw_mis",   1'b0, 3'b010, 32'h0000_0005, 2'b01);
    do_err("ld_ill",   1'b0, 3'b111, 32'h0000_0008, 2'b10);
    do_err("st_ill",   1'b1, 3'b100, 32'h0000_0001, 2'b10);
    do_err("sh_mis",   1'b1, 3'b001, 32'h0000_0003, 2'b01);
    do_err("lhu_mis",  1'b0, 3'b101, 32'h0000_0011, 2'b01);

    do_wait("tmo",     3'b101, 32'h0000_0010, 0,  32'h0,          15, 2'b11, 32'h0);
    do_wait("ack15",   3'b101, 32'h0000_0010, 15, 32'h1234_8765,  15, 2'b00, 32'h0000_8765);
    do_wait("ack3",    3'b000, 32'h0000_0012, 3,  32'h0055_0000,  3,  2'b00, 32'h0000_0055);

    // Reset during the third BUS cycle aborts the access.
    issue(1'b0, 3'b010, 32'h0000_0020, 32'd0);
    tick; tick;
    check("abort_in_bus", 32'(mem_req), 32'd1);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    check("abort_mem_req", 32'(mem_req),   32'd0);
    check("abort_ready",   32'(req_ready), 32'd1);
    check("abort_no_rsp",  32'(rsp_valid), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick;
    mem_ack = 1'b0; mem_rdata = '0;
    check("spur_no_rsp",  32'(rsp_valid), 32'd0);
    check("spur_mem_req", 32'(mem_req),   32'd0);
    tick;
    check("spur_no_rsp2", 32'(rsp_valid), 32'd0);
    check("spur_ready",   32'(req_ready), 32'd1);

    // Back-to-back: request held, ack held; address garbled while busy.
    acc_n = 0; rsp_n = 0; last_acc = -100; min_gap = 1000;
    bad_addr = 0; bad_ready = 0; bad_data = 0;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_wdata = '0;
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    for (int c = 0; c < 12; c++) begin
      req_addr = req_ready ? 32'h0000_0040 : 32'h0000_0999;
      if (req_ready) begin
        if (c - last_acc < min_gap) min_gap = c - last_acc;
        last_acc = c;
        acc_n++;
      end
      if ((mem_req || rsp_valid) && req_ready) bad_ready++;
      if (mem_req && mem_addr != 32'h0000_0040) bad_addr++;
      if (rsp_valid) begin
        rsp_n++;
        if (rsp_rdata != 32'h1111_1111 || rsp_code != 2'b00) bad_data++;
      end
      tick;
    end
    req_valid = 1'b0; req_addr = '0; req_funct3 = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    check("b2b_accepts",   32'(acc_n),     32'd4);
    check("b2b_min_gap",   32'(min_gap),   32'd3);
    check("b2b_rsps",      32'(rsp_n),     32'd4);
    check("b2b_ready_off", 32'(bad_ready), 32'd0);
    check("b2b_addr_held", 32'(bad_addr),  32'd0);
    check("b2b_data",      32'(bad_data),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 15, is the number of cycles to wait for mem_ack before aborting (range 1..255).
REQ-002 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1: synchronous, active-low reset.
REQ-004 Port req_valid, input, 1: the pipeline presents an access.
REQ-005 Port req_ready, output, 1: the unit accepts an access this cycle.
REQ-006 Port req_store, input, 1: 1 = store, 0 = load.
REQ-007 Port req_funct3, input, 3: RV32I width/sign code.
REQ-008 Port req_addr, input, 32: byte address.
REQ-009 Port req_wdata, input, 32: store data, right-justified.
REQ-010 Port rsp_valid, output, 1: one-cycle completion pulse.
REQ-011 Port rsp_rdata, output, 32: extended load result; 0 for stores and errors.
REQ-012 Port rsp_code, output, 2: 00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
REQ-013 Port mem_req, output, 1: memory access request.
REQ-014 Port mem_we, output, 1: write enable.
REQ-015 Port mem_addr, output, 32: word-aligned address.
REQ-016 Port mem_wstrb, output, 4: byte-lane enables.
REQ-017 Port mem_wdata, output, 32: lane-replicated store data.
REQ-018 Port mem_ack, input, 1: memory completion.
REQ-019 Port mem_rdata, input, 32: little-endian read word, valid with mem_ack.

Function
REQ-020 The FSM SHALL have states IDLE, BUS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 On req_valid and req_ready, the unit SHALL register all req_* inputs and classify the access.
- Illegal: load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
- Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
- Illegal funct3 takes priority over misaligned.
REQ-022 A legal, aligned access SHALL move IDLE->BUS; an error SHALL move IDLE->RESP with the matching rsp_code and no mem_req.
REQ-023 In BUS, mem_req SHALL be 1, with mem_addr, mem_we, mem_wstrb and mem_wdata held constant until exit.
- mem_addr = {addr[31:2],2'b00}.
REQ-024 Store lanes SHALL be driven as follows:
- SB: mem_wdata = {4{wdata[7:0]}}, mem_wstrb = 0001 shifted left by addr[1:0].
- SH: mem_wdata = {2{wdata[15:0]}}, mem_wstrb = 0011 when addr[1]=0, else 1100.
- SW: mem_wdata = wdata, mem_wstrb = 1111.
- For loads, mem_wstrb = 0000.
REQ-025 On mem_ack in BUS, the unit SHALL capture mem_rdata, move to RESP and drop mem_req the next cycle.
REQ-026 Load extraction SHALL operate on the captured word:
- LB/LBU use the byte at lane addr[1:0], sign-/zero-extended.
- LH/LHU use halfword addr[1], sign-/zero-extended.
- LW uses the full word.
REQ-027 An 8-bit wait counter SHALL clear on BUS entry and increment each BUS cycle without mem_ack.
- When the counter reaches TIMEOUT-1 without an ack, the unit SHALL move to RESP with rsp_code 11 and rsp_rdata 0.
- mem_ack arriving in that same cycle SHALL win, giving a normal completion.
REQ-028 RESP SHALL last exactly one cycle with rsp_valid=1 and then return to IDLE; rsp_valid SHALL be 0 in every other state.
REQ-029 Latency: accept in cycle N, mem_req in N+1; if mem_ack arrives in N+k, rsp_valid is in N+k+1. Errors give rsp_valid in N+1. Minimum issue interval is 3 cycles.
REQ-030 mem_ack outside BUS SHALL be ignored.
REQ-031 req_* inputs outside IDLE SHALL be ignored.

Reset
REQ-032 While rst=0 at a clock edge, the unit SHALL enter IDLE and clear the counter and all registered state.
- Reset outputs: req_ready=1; rsp_valid=0, rsp_code=00, rsp_rdata=0; mem_req=0, mem_we=0, mem_wstrb=0000, mem_addr=0, mem_wdata=0.
REQ-033 Reset asserted in BUS or RESP SHALL abort the access: mem_req=0 after that edge and no rsp_valid is produced for it.

Verification
REQ-034 LB at addr 0x103 with mem_rdata 0x80FF_1234 acked the cycle after mem_req -> mem_addr 0x100, wstrb 0000, rsp_rdata 0xFFFF_FF80, rsp_code 00, rsp_valid 2 cycles after accept.
REQ-035 SH at addr 0x202, wdata 0x0000_ABCD -> mem_we 1, mem_addr 0x200, wstrb 1100, mem_wdata 0xABCD_ABCD, rsp_rdata 0.
REQ-036 LW at addr 0x005 -> no mem_req, rsp_valid next cycle with rsp_code 01; load funct3 111 at aligned addr -> rsp_code 10.
REQ-037 With TIMEOUT=15 and no ack: LHU at 0x10 -> mem_req high exactly 15 cycles, then rsp_code 11. Repeat with ack on the 15th cycle -> rsp_code 00 with the data.
REQ-038 rst=0 during the 3rd BUS cycle -> mem_req=0 and req_ready=1 after the edge, no rsp_valid, and a spurious mem_ack next cycle is ignored.
REQ-039 Back-to-back req_valid held high -> accepts spaced at least 3 cycles apart; req_ready stays 0 during BUS/RESP and the held request is not re-sampled.
